hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage core. Decides every cycle whether the IF/ID register latches, holds or flushes, whether ID/EX receives a bubble, and whether the whole pipeline freezes on a slow data-memory access. It sits beside the ID stage, drives the IFID `hold`/`flush` pins and the PC write enable, and keeps saturating stall/flush performance counters plus a sticky memory-timeout flag.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, register-zero
// constant and the source/destination match helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 never carries a real dependency.
  function automatic logic src_match(input logic [4:0] dst, input logic [4:0] src);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all ones; clear and reset both force zero.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: load-use and
// branch-operand stalls, ID redirect flushes and dmem wait freezes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_redirect,
  input  logic             idex_memread,
  input  logic             idex_regwrite,
  input  logic [4:0]       idex_dst,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic [4:0]       exmem_dst,
  input  logic             dmem_ready,
  input  logic             cnt_clear,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;

  logic ex_match, mem_match;
  logic load_use, br_ex, br_mem, stall_raw;
  logic mem_acc, hit_to;
  logic freeze, stall, flush;

  // Dependency detection against the EX and MEM destinations
  always_comb begin
    ex_match  = src_match(idex_dst, id_rs) || (id_uses_rt && src_match(idex_dst, id_rt));
    mem_match = src_match(exmem_dst, id_rs) || (id_uses_rt && src_match(exmem_dst, id_rt));
    load_use  = idex_memread && ex_match;
    br_ex     = id_branch && idex_regwrite && !idex_memread && ex_match;
    br_mem    = id_branch && exmem_memread && mem_match;
    stall_raw = load_use || br_ex || br_mem;
    mem_acc   = exmem_memread || exmem_memwrite;
  end

  // Next state and prioritised hazard outputs
  always_comb begin
    state_d = state_q;
    hit_to  = 1'b0;
    freeze  = 1'b0;
    case (state_q)
      ST_RUN: begin
        freeze = mem_acc && !dmem_ready;
        if (mem_acc && !dmem_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // A late ready on the timeout cycle counts as normal completion.
        hit_to = !dmem_ready && (wait_q == TO_VAL);
        freeze = !dmem_ready && !hit_to;
        if (dmem_ready || hit_to) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) freeze = 1'b0;
    stall = !reset && !freeze && stall_raw;
    flush = !reset && !freeze && !stall_raw && id_redirect;
  end

  assign pc_hold     = freeze || stall;
  assign ifid_hold   = freeze || stall;
  assign idex_bubble = stall;
  assign pipe_freeze = freeze;
  assign ifid_flush  = flush;
  assign mem_timeout = timeout_q;

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) begin
        wait_q <= '0;
      end else if (state_d == ST_MEM_WAIT) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      timeout_q <= 1'b0;
    end else if (hit_to) begin
      timeout_q <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (freeze || stall),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  localparam logic [4:0] HZ_NONE   = 5'b00000;
  localparam logic [4:0] HZ_STALL  = 5'b11010;
  localparam logic [4:0] HZ_FREEZE = 5'b11001;
  localparam logic [4:0] HZ_FLUSH  = 5'b00100;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, idex_dst, exmem_dst;
  logic id_uses_rt, id_branch, id_redirect;
  logic idex_memread, idex_regwrite, exmem_memread, exmem_memwrite;
  logic dmem_ready, cnt_clear;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [4:0] hz;

  int tests = 0;
  int fails = 0;

  assign hz = {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rt     (id_uses_rt),
    .id_branch      (id_branch),
    .id_redirect    (id_redirect),
    .idex_memread   (idex_memread),
    .idex_regwrite  (idex_regwrite),
    .idex_dst       (idex_dst),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .exmem_dst      (exmem_dst),
    .dmem_ready     (dmem_ready),
    .cnt_clear      (cnt_clear),
    .pc_hold        (pc_hold),
    .ifid_hold      (ifid_hold),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .pipe_freeze    (pipe_freeze),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0; id_redirect = 0;
    idex_memread = 0; idex_regwrite = 0; idex_dst = 0;
    exmem_memread = 0; exmem_memwrite = 0; exmem_dst = 0;
    dmem_ready = 1; cnt_clear = 0;
  endtask

  task automatic clr();
    idle();
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    idex_memread = 1; idex_dst = 2; id_rs = 2; id_redirect = 1;
    exmem_memread = 1; dmem_ready = 0;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL reset_outputs got %b want %b", hz, HZ_NONE); end
    tick(); tick();
    tests++; if (stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 0) begin
      fails++; $display("FAIL reset_state got stall=%0d flush=%0d to=%b want 0 0 0", stall_cnt, flush_cnt, mem_timeout);
    end
    idle();
    reset = 0;
    tick();
  endtask

  task automatic test_load_use();
    clr();
    idex_memread = 1; idex_dst = 2; id_rs = 2;
    #1;
    tests++; if (hz !== HZ_STALL) begin fails++; $display("FAIL load_use got %b want %b", hz, HZ_STALL); end
    tick();
    idle();
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL load_use_after got %b want %b", hz, HZ_NONE); end
    tests++; if (stall_cnt !== 1) begin fails++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
    // ALU result in EX feeding a branch compare in ID
    idex_regwrite = 1; idex_dst = 4; id_rt = 4; id_uses_rt = 1; id_branch = 1;
    #1;
    tests++; if (hz !== HZ_STALL) begin fails++; $display("FAIL br_ex got %b want %b", hz, HZ_STALL); end
    id_branch = 0;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL alu_fwd got %b want %b", hz, HZ_NONE); end
    idle();
  endtask

  task automatic test_load_branch();
    clr();
    idex_memread = 1; idex_dst = 3;
    id_branch = 1; id_rs = 3; id_rt = 0; id_uses_rt = 1; id_redirect = 1;
    #1;
    tests++; if (hz !== HZ_STALL) begin fails++; $display("FAIL lb_cycle1 got %b want %b", hz, HZ_STALL); end
    tick();
    idex_memread = 0; idex_dst = 0;
    exmem_memread = 1; exmem_dst = 3; dmem_ready = 1;
    #1;
    tests++; if (hz !== HZ_STALL) begin fails++; $display("FAIL lb_cycle2 got %b want %b", hz, HZ_STALL); end
    tick();
    exmem_memread = 0; exmem_dst = 0;
    #1;
    tests++; if (hz !== HZ_FLUSH) begin fails++; $display("FAIL lb_cycle3 got %b want %b", hz, HZ_FLUSH); end
    tick();
    idle();
    tests++; if (stall_cnt !== 2 || flush_cnt !== 1) begin
      fails++; $display("FAIL lb_cnt got stall=%0d flush=%0d want 2 1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_uses_rt();
    idle();
    idex_memread = 1; idex_dst = 5; id_rs = 1; id_rt = 5;
    id_uses_rt = 0;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL rt_unused got %b want %b", hz, HZ_NONE); end
    id_uses_rt = 1;
    #1;
    tests++; if (hz !== HZ_STALL) begin fails++; $display("FAIL rt_used got %b want %b", hz, HZ_STALL); end
    idex_dst = 0; id_rs = 0; id_rt = 0;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL reg0_used got %b want %b", hz, HZ_NONE); end
    id_uses_rt = 0;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL reg0_unused got %b want %b", hz, HZ_NONE); end
    idle();
  endtask

  task automatic test_mem_freeze();
    clr();
    exmem_memread = 1; dmem_ready = 0;
    idex_memread = 1; idex_dst = 2; id_rs = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (hz !== HZ_FREEZE) begin fails++; $display("FAIL freeze_c%0d got %b want %b", i, hz, HZ_FREEZE); end
      tick();
      idex_memread = 0; idex_dst = 0; id_rs = 0;
    end
    dmem_ready = 1;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL freeze_release got %b want %b", hz, HZ_NONE); end
    tick();
    idle();
    tests++; if (stall_cnt !== 3 || mem_timeout !== 0) begin
      fails++; $display("FAIL freeze_cnt got stall=%0d to=%b want 3 0", stall_cnt, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    clr();
    exmem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (hz !== HZ_FREEZE) begin fails++; $display("FAIL to_freeze_c%0d got %b want %b", i, hz, HZ_FREEZE); end
      tick();
    end
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL to_fire got %b want %b", hz, HZ_NONE); end
    exmem_memread = 0;
    tick();
    #1;
    tests++; if (mem_timeout !== 1 || pipe_freeze !== 0) begin
      fails++; $display("FAIL to_flag got to=%b freeze=%b want 1 0", mem_timeout, pipe_freeze);
    end
    tests++; if (stall_cnt !== 5) begin fails++; $display("FAIL to_cnt got %0d want 5", stall_cnt); end
    tick();
    tests++; if (mem_timeout !== 1) begin fails++; $display("FAIL to_sticky got %b want 1", mem_timeout); end
    clr();
    tests++; if (mem_timeout !== 0) begin fails++; $display("FAIL to_clear got %b want 0", mem_timeout); end
  endtask

  task automatic test_ready_at_timeout();
    clr();
    exmem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) tick();
    dmem_ready = 1;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL rdy_to got %b want %b", hz, HZ_NONE); end
    tick();
    idle();
    tests++; if (mem_timeout !== 0 || stall_cnt !== 5) begin
      fails++; $display("FAIL rdy_to_state got to=%b stall=%0d want 0 5", mem_timeout, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    clr();
    exmem_memread = 1; dmem_ready = 0;
    tick(); tick();
    reset = 1;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL rst_wait_out got %b want %b", hz, HZ_NONE); end
    tick();
    reset = 0;
    exmem_memread = 0; dmem_ready = 0;
    #1;
    tests++; if (hz !== HZ_NONE) begin fails++; $display("FAIL rst_wait_run got %b want %b", hz, HZ_NONE); end
    tests++; if (stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 0) begin
      fails++; $display("FAIL rst_wait_cnt got stall=%0d flush=%0d to=%b want 0 0 0", stall_cnt, flush_cnt, mem_timeout);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    clr();
    id_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (hz !== HZ_FLUSH) begin fails++; $display("FAIL b2b_flush_c%0d got %b want %b", i, hz, HZ_FLUSH); end
      tick();
    end
    tests++; if (flush_cnt !== 3) begin fails++; $display("FAIL b2b_flush_cnt got %0d want 3", flush_cnt); end
    idex_memread = 1; idex_dst = 7; id_rs = 7;
    #1;
    tests++; if (hz !== HZ_STALL) begin fails++; $display("FAIL stall_over_redirect got %b want %b", hz, HZ_STALL); end
    for (int i = 0; i < 18; i++) tick();
    tests++; if (stall_cnt !== 4'hF) begin fails++; $display("FAIL stall_sat got %0d want 15", stall_cnt); end
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    tests++; if (stall_cnt !== 0 || flush_cnt !== 0) begin
      fails++; $display("FAIL clear_wins got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_uses_rt();
    test_mem_freeze();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
